// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and latency constants for the decode scoreboard.
// A latency of all-ones means the producer's latency is unknown (wait for writeback).
package rv_pipe_pkg;

  localparam int unsigned SB_LAT_W = 4;

  function automatic int unsigned lat_inf(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  typedef struct packed {
    logic                busy;
    logic [SB_LAT_W-1:0] cnt;
  } sb_entry_t;

  localparam logic [SB_LAT_W-1:0] LAT_ALU  = SB_LAT_W'(0);
  localparam logic [SB_LAT_W-1:0] LAT_LOAD = SB_LAT_W'(1);
  localparam logic [SB_LAT_W-1:0] LAT_MUL  = SB_LAT_W'(2);
  localparam logic [SB_LAT_W-1:0] LAT_DIV  = SB_LAT_W'(lat_inf(SB_LAT_W));

endpackage

// File: rtl/decode_scoreboard_entry.sv
// One register's scoreboard state: busy flag plus a latency countdown.
// Priority: set (new producer) over clear (wb/kill) over countdown.
module sb_entry
  import rv_pipe_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic             clr,
  output logic             busy,
  output logic [LAT_W-1:0] cnt,
  output logic             busy_nxt
);

  localparam logic [LAT_W-1:0] INF = LAT_W'(lat_inf(LAT_W));

  sb_entry_t  ent_d, ent_q;

  always_comb begin
    ent_d = ent_q;
    if (set) begin
      ent_d.busy = 1'b1;
      ent_d.cnt  = set_lat;
    end else if (clr) begin
      ent_d.busy = 1'b0;
      ent_d.cnt  = '0;
    end else if (!hold && ent_q.busy && ent_q.cnt != '0 && ent_q.cnt != INF) begin
      ent_d.cnt = ent_q.cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign busy     = ent_q.busy;
  assign cnt      = ent_q.cnt;
  assign busy_nxt = ent_d.busy;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: per-register busy/latency state, combinational
// RAW/WAW hazard query, and update on issue, writeback and kill.
module decode_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int RIDX_W   = $clog2(NREG),
  parameter int NSRC     = 3,
  parameter int NWB      = 2,
  parameter int LAT_W    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   Rst_n,
  input  logic                   hold,
  input  logic                   issue_valid,
  input  logic                   issue_regwrite,
  input  logic [RIDX_W-1:0]      issue_rd,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [NSRC-1:0]        src_en,
  input  logic [NSRC*RIDX_W-1:0] src_idx,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*RIDX_W-1:0]  wb_rd,
  input  logic                   kill,
  input  logic [RIDX_W-1:0]      kill_rd,
  output logic                   hz,
  output logic [NSRC-1:0]        src_busy,
  output logic [NREG-1:0]        busy_vec,
  output logic [RIDX_W:0]        pending_cnt
);

  localparam logic [LAT_W-1:0] INF = LAT_W'(lat_inf(LAT_W));

  logic [NREG-1:0]  busy_arr;
  logic [NREG-1:0]  busy_nxt;
  logic [LAT_W-1:0] cnt_arr [NREG];
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;
  logic [NSRC-1:0]  src_busy_c;
  logic             waw_c;
  logic             hz_c;
  logic             accept;
  logic [RIDX_W:0]  pending_cnt_d, pending_cnt_q;

  function automatic logic [RIDX_W:0] popcnt(input logic [NREG-1:0] v);
    logic [RIDX_W:0] s;
    s = '0;
    for (int i = 0; i < NREG; i++) s = s + (RIDX_W+1)'(v[i]);
    return s;
  endfunction

  // Hazard query: a source is pending until its producer's countdown reaches zero.
  always_comb begin
    logic [RIDX_W-1:0] idx;
    idx        = '0;
    src_busy_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx = src_idx[i*RIDX_W +: RIDX_W];
      src_busy_c[i] = src_en[i] && busy_arr[idx] && (cnt_arr[idx] != '0);
    end
    waw_c  = issue_regwrite && busy_arr[issue_rd] && (cnt_arr[issue_rd] == INF);
    hz_c   = (|src_busy_c) || waw_c;
    accept = issue_valid && !hold && !hz_c;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      set_vec[r] = accept && issue_regwrite && (issue_rd == RIDX_W'(r)) &&
                   !(ZERO_REG && r == 0);
      clr_vec[r] = kill && (kill_rd == RIDX_W'(r));
      for (int p = 0; p < NWB; p++) begin
        if (wb_valid[p] && wb_rd[p*RIDX_W +: RIDX_W] == RIDX_W'(r)) clr_vec[r] = 1'b1;
      end
    end
  end

  // Register 0 is tied off by never asserting its set input when ZERO_REG is on.
  for (genvar r = 0; r < NREG; r++) begin : g_ent
    sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk      (clk),
      .rst_n    (Rst_n),
      .hold     (hold),
      .set      (set_vec[r]),
      .set_lat  (issue_lat),
      .clr      (clr_vec[r]),
      .busy     (busy_arr[r]),
      .cnt      (cnt_arr[r]),
      .busy_nxt (busy_nxt[r])
    );
  end

  always_comb pending_cnt_d = popcnt(busy_nxt);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending_cnt_q <= '0;
    end else begin
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign hz          = hz_c;
  assign src_busy    = src_busy_c;
  assign busy_vec    = busy_arr;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Randomized and directed bench for decode_scoreboard against a ready-time model.
module tb_decode_scoreboard;

  localparam int NREG = 32, RW = 5, NSRC = 3, NWB = 2, LW = 4;
  localparam logic [LW-1:0] INF = 4'hF;

  logic             clk = 1'b0;
  logic             Rst_n;
  logic             hold, issue_valid, issue_regwrite, kill;
  logic [RW-1:0]    issue_rd, kill_rd;
  logic [LW-1:0]    issue_lat;
  logic [NSRC-1:0]  src_en;
  logic [NSRC*RW-1:0] src_idx;
  logic [NWB-1:0]   wb_valid;
  logic [NWB*RW-1:0] wb_rd;
  logic             hz;
  logic [NSRC-1:0]  src_busy;
  logic [NREG-1:0]  busy_vec;
  logic [RW:0]      pending_cnt;

  decode_scoreboard #(.NREG(NREG), .NSRC(NSRC), .NWB(NWB), .LAT_W(LW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .Rst_n(Rst_n), .hold(hold), .issue_valid(issue_valid),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .src_en(src_en), .src_idx(src_idx), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .kill(kill), .kill_rd(kill_rd), .hz(hz), .src_busy(src_busy),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a register is busy until writeback/kill; its result becomes usable once
  // the count of unheld cycles reaches its ready time (never, for unknown latency).
  bit     m_busy [NREG];
  bit     m_inf  [NREG];
  longint m_ready[NREG];
  longint act;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pending(input int r);
    return m_busy[r] && (m_inf[r] || act < m_ready[r]);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 0; m_inf[r] = 0; m_ready[r] = 0;
    end
    act = 0;
  endtask

  task automatic idle();
    hold = 0; issue_valid = 0; issue_regwrite = 0; issue_rd = '0; issue_lat = '0;
    src_en = '0; src_idx = '0; wb_valid = '0; wb_rd = '0; kill = 0; kill_rd = '0;
  endtask

  task automatic issue(input int rd, input logic [LW-1:0] lat);
    issue_valid = 1; issue_regwrite = 1; issue_rd = RW'(rd); issue_lat = lat;
  endtask

  task automatic set_src(input int i, input int r);
    src_en[i] = 1'b1;
    src_idx[i*RW +: RW] = RW'(r);
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic [NSRC-1:0] e_sb;
    logic [NREG-1:0] e_bv;
    logic e_waw, e_hz, acc;
    int e_pc;
    #1;
    e_sb = '0;
    for (int i = 0; i < NSRC; i++)
      if (src_en[i] && m_pending(int'(src_idx[i*RW +: RW]))) e_sb[i] = 1'b1;
    e_waw = issue_regwrite && m_busy[issue_rd] && m_inf[issue_rd];
    e_hz  = (|e_sb) || e_waw;
    e_pc  = 0;
    for (int r = 0; r < NREG; r++) begin
      e_bv[r] = m_busy[r];
      e_pc += int'(m_busy[r]);
    end
    chk("hz", 64'(hz), 64'(e_hz));
    chk("src_busy", 64'(src_busy), 64'(e_sb));
    chk("busy_vec", 64'(busy_vec), 64'(e_bv));
    chk("pending_cnt", 64'(pending_cnt), 64'(e_pc));
    acc = issue_valid && !hold && !e_hz;
    @(posedge clk);
    for (int p = 0; p < NWB; p++)
      if (wb_valid[p]) m_busy[wb_rd[p*RW +: RW]] = 0;
    if (kill) m_busy[kill_rd] = 0;
    if (acc && issue_regwrite && issue_rd != 0) begin
      m_busy[issue_rd]  = 1;
      m_inf[issue_rd]   = (issue_lat == INF);
      m_ready[issue_rd] = act + longint'(issue_lat) + 1;
    end
    if (!hold) act++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    Rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_pending", 64'(pending_cnt), 64'h0);
    @(negedge clk);
    Rst_n = 1;

    // Idle query
    set_src(0, 5); set_src(1, 6); set_src(2, 0);
    #1 chk("idle_hz", 64'(hz), 64'h0);
    chk("idle_src_busy", 64'(src_busy), 64'h0);
    cycle();

    // rd=5 with latency 2
    idle(); issue(5, 4'd2); set_src(0, 5);
    cycle();
    issue_valid = 0; issue_regwrite = 0;
    #1 chk("lat2_t1", 64'(src_busy[0]), 64'h1);
    cycle();
    #1 chk("lat2_t2", 64'(src_busy[0]), 64'h1);
    cycle();
    #1 chk("lat2_t3", 64'(src_busy[0]), 64'h0);
    chk("lat2_still_busy", 64'(busy_vec[5]), 64'h1);
    cycle();
    wb_valid = 2'b01; wb_rd[0 +: RW] = RW'(5);
    cycle();
    wb_valid = '0;
    #1 chk("lat2_wb_pending", 64'(pending_cnt), 64'h0);
    cycle();

    // rd=7 unknown latency, WAW, cleared by long-latency writeback
    idle(); issue(7, INF);
    cycle();
    idle(); set_src(1, 7);
    for (int k = 0; k < 5; k++) begin
      #1 chk("inf_stall", 64'(hz), 64'h1);
      cycle();
    end
    idle(); issue(7, 4'd1);
    #1 chk("waw_hz", 64'(hz), 64'h1);
    cycle();
    idle(); set_src(1, 7); wb_valid = 2'b10; wb_rd[RW +: RW] = RW'(7);
    cycle();
    wb_valid = '0;
    #1 chk("inf_release", 64'(hz), 64'h0);
    cycle();

    // hold freezes the countdown and blocks issue
    idle(); issue(9, 4'd3);
    cycle();
    idle(); hold = 1; issue(10, 4'd1); set_src(0, 9);
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_frozen", 64'(src_busy[0]), 64'h1);
      cycle();
    end
    hold = 0; issue_valid = 0; issue_regwrite = 0;
    #1 chk("hold_no_issue", 64'(busy_vec[10]), 64'h0);
    cycle(); cycle();
    #1 chk("hold_k2", 64'(src_busy[0]), 64'h1);
    cycle();
    #1 chk("hold_k3", 64'(src_busy[0]), 64'h0);
    cycle();
    idle(); wb_valid = 2'b01; wb_rd[0 +: RW] = RW'(9);
    cycle();

    // Issue beats writeback on the same register; kill then clears it
    idle(); issue(4, 4'd2);
    cycle();
    issue(4, 4'd1); wb_valid = 2'b01; wb_rd[0 +: RW] = RW'(4);
    cycle();
    idle(); set_src(0, 4); kill = 1; kill_rd = RW'(4);
    #1 chk("iss_beats_wb_busy", 64'(busy_vec[4]), 64'h1);
    chk("iss_beats_wb_cnt1", 64'(src_busy[0]), 64'h1);
    cycle();
    idle();
    #1 chk("kill_clears", 64'(busy_vec[4]), 64'h0);
    cycle();

    // Register 0 never becomes busy
    idle(); issue(0, INF);
    cycle();
    idle(); set_src(0, 0);
    #1 chk("zero_busy_vec", 64'(busy_vec), 64'h0);
    chk("zero_hz", 64'(hz), 64'h0);
    cycle();

    // Asynchronous reset mid-countdown
    idle(); issue(12, 4'd6);
    cycle();
    idle(); set_src(0, 12);
    cycle();
    #2 Rst_n = 0;
    #1 chk("arst_busy_vec", 64'(busy_vec), 64'h0);
    chk("arst_pending", 64'(pending_cnt), 64'h0);
    chk("arst_hz", 64'(hz), 64'h0);
    model_reset();
    @(negedge clk);
    Rst_n = 1;
    idle(); issue(12, 4'd1); set_src(0, 12);
    cycle();
    idle(); set_src(0, 12);
    cycle(); cycle();

    // Randomized traffic on a small register window to force interactions
    for (int n = 0; n < 2000; n++) begin
      int lsel;
      hold           = ($urandom_range(0, 99) < 15);
      issue_valid    = ($urandom_range(0, 99) < 55);
      issue_regwrite = ($urandom_range(0, 99) < 85);
      issue_rd       = RW'($urandom_range(0, 7));
      lsel           = $urandom_range(0, 5);
      issue_lat      = (lsel == 5) ? INF : LW'(lsel);
      src_en         = NSRC'($urandom);
      for (int i = 0; i < NSRC; i++) src_idx[i*RW +: RW] = RW'($urandom_range(0, 7));
      for (int p = 0; p < NWB; p++) begin
        wb_valid[p] = ($urandom_range(0, 99) < 20);
        wb_rd[p*RW +: RW] = RW'($urandom_range(0, 7));
      end
      kill    = ($urandom_range(0, 99) < 8);
      kill_rd = RW'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
